// File: rtl/regfile_if.sv
// regfile_if: connection bundle between the register file and its neighbours
// (ROB commit/query side, issue-time rename marks, two decoder read ports).
//
// Parameters
//   ROB_BITS  width of a ROB id (ROB holds 2**ROB_BITS entries)
//
// Signals (direction seen from the register file, i.e. modport slave)
//   rdy_in           in   0 = freeze all state
//   rob_clear        in   mispredict flush, drops every rename tag
//   set_id           in   commit destination register (0 = no commit)
//   set_val          in   commit value
//   set_from_rob_id  in   ROB id of the committing entry
//   set_dep_id       in   issue destination register (0 = no mark)
//   set_dep_Q        in   ROB id that will produce set_dep_id
//   rsN_id           in   read port N register index
//   rsN_val          out  read port N value (valid when rsN_has_dep=0)
//   rsN_has_dep      out  value pending in ROB entry rsN_dep
//   rsN_dep          out  producing ROB id (0 when no dependency)
//   get_rob_id_N     out  ROB query N, tag of rsN_id
//   rob_avail_N      in   ROB entry get_rob_id_N has its result
//   rob_val_N        in   result of ROB entry get_rob_id_N
//
// Modports: master = environment (ROB/decoder), slave = register file.
interface regfile_if #(
  parameter int ROB_BITS = 4
);
  logic                rdy_in;
  logic                rob_clear;
  logic [4:0]          set_id;
  logic [31:0]         set_val;
  logic [ROB_BITS-1:0] set_from_rob_id;
  logic [4:0]          set_dep_id;
  logic [ROB_BITS-1:0] set_dep_Q;

  logic [4:0]          rs1_id;
  logic [31:0]         rs1_val;
  logic                rs1_has_dep;
  logic [ROB_BITS-1:0] rs1_dep;
  logic [4:0]          rs2_id;
  logic [31:0]         rs2_val;
  logic                rs2_has_dep;
  logic [ROB_BITS-1:0] rs2_dep;

  logic [ROB_BITS-1:0] get_rob_id_1;
  logic                rob_avail_1;
  logic [31:0]         rob_val_1;
  logic [ROB_BITS-1:0] get_rob_id_2;
  logic                rob_avail_2;
  logic [31:0]         rob_val_2;

  modport master (
    output rdy_in, rob_clear, set_id, set_val, set_from_rob_id,
           set_dep_id, set_dep_Q, rs1_id, rs2_id,
           rob_avail_1, rob_val_1, rob_avail_2, rob_val_2,
    input  rs1_val, rs1_has_dep, rs1_dep, rs2_val, rs2_has_dep, rs2_dep,
           get_rob_id_1, get_rob_id_2
  );

  modport slave (
    input  rdy_in, rob_clear, set_id, set_val, set_from_rob_id,
           set_dep_id, set_dep_Q, rs1_id, rs2_id,
           rob_avail_1, rob_val_1, rob_avail_2, rob_val_2,
    output rs1_val, rs1_has_dep, rs1_dep, rs2_val, rs2_has_dep, rs2_dep,
           get_rob_id_1, get_rob_id_2
  );
endinterface

// File: rtl/regfile.sv
// regfile: architectural register file with rename tags, downstream of the ROB.
//   - ROB commits write values and release a tag if it is still the newest one.
//   - Issue-time marks set a register busy on a producing ROB id.
//   - Two zero-latency read ports return either a value or a pending tag;
//     pending tags are resolved through the ROB value-query ports.
//
// Ports
//   clk_in   clock, rising edge
//   rst_in   synchronous reset, active-low (clears values and tags)
//   bus      regfile_if.slave, see regfile_if.sv for the signal list
//
// Parameters
//   ROB_BITS  width of a ROB id
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read of a register being committed in
//                      the same cycle (with the matching tag) returns set_val
//                      directly instead of going through the ROB query.
module regfile #(
  parameter int ROB_BITS = 4
) (
  input  logic      clk_in,
  input  logic      rst_in,
  regfile_if.slave  bus
);

  logic [31:0]         val_q  [32];
  logic                busy_q [32];
  logic [ROB_BITS-1:0] tag_q  [32];

  // Later assignments in this block take priority: a mark overrides the
  // tag release of a same-cycle commit, and a flush overrides every mark.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (bus.rdy_in) begin
      if (bus.set_id != 5'd0) begin
        val_q[bus.set_id] <= bus.set_val;
        // Only release if no newer rename has replaced this tag.
        if (busy_q[bus.set_id] && (tag_q[bus.set_id] == bus.set_from_rob_id))
          busy_q[bus.set_id] <= 1'b0;
      end
      if (bus.set_dep_id != 5'd0) begin
        busy_q[bus.set_dep_id] <= 1'b1;
        tag_q[bus.set_dep_id]  <= bus.set_dep_Q;
      end
      if (bus.rob_clear) begin
        for (int i = 0; i < 32; i++)
          busy_q[i] <= 1'b0;
      end
    end
  end

  // x0 is never written, so its tag stays 0 and the query port reads 0.
  assign bus.get_rob_id_1 = tag_q[bus.rs1_id];
  assign bus.get_rob_id_2 = tag_q[bus.rs2_id];

  always_comb begin
    bus.rs1_val     = '0;
    bus.rs1_has_dep = 1'b0;
    bus.rs1_dep     = '0;
    if (bus.rs1_id == 5'd0) begin
      bus.rs1_val = '0;
`ifdef REGFILE_BYPASS_EN
    end else if ((bus.rs1_id == bus.set_id) && busy_q[bus.rs1_id] &&
                 (tag_q[bus.rs1_id] == bus.set_from_rob_id)) begin
      bus.rs1_val = bus.set_val;
`endif
    end else if (!busy_q[bus.rs1_id]) begin
      bus.rs1_val = val_q[bus.rs1_id];
    end else if (bus.rob_avail_1) begin
      bus.rs1_val = bus.rob_val_1;
    end else begin
      bus.rs1_has_dep = 1'b1;
      bus.rs1_dep     = tag_q[bus.rs1_id];
    end
  end

  always_comb begin
    bus.rs2_val     = '0;
    bus.rs2_has_dep = 1'b0;
    bus.rs2_dep     = '0;
    if (bus.rs2_id == 5'd0) begin
      bus.rs2_val = '0;
`ifdef REGFILE_BYPASS_EN
    end else if ((bus.rs2_id == bus.set_id) && busy_q[bus.rs2_id] &&
                 (tag_q[bus.rs2_id] == bus.set_from_rob_id)) begin
      bus.rs2_val = bus.set_val;
`endif
    end else if (!busy_q[bus.rs2_id]) begin
      bus.rs2_val = val_q[bus.rs2_id];
    end else if (bus.rob_avail_2) begin
      bus.rs2_val = bus.rob_val_2;
    end else begin
      bus.rs2_has_dep = 1'b1;
      bus.rs2_dep     = tag_q[bus.rs2_id];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed-vector bench for regfile with a scoreboard queue.
// Stimulus drives a read and pushes the expected response; a monitor on the
// falling clock edge pops each pending entry and compares it with the DUT.
module tb_regfile;

  localparam int RB = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  regfile_if #(.ROB_BITS(RB)) bus ();

  regfile #(.ROB_BITS(RB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct {
    int          port;
    logic [31:0] val;
    logic        hd;
    logic [RB-1:0] dep;
    logic [RB-1:0] grid;
    bit          chk_grid;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compare every expectation queued during this cycle.
  always @(negedge clk_in) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a_val;
      logic        a_hd;
      logic [RB-1:0] a_dep, a_grid;
      e = sb.pop_front();
      if (e.port == 1) begin
        a_val = bus.rs1_val; a_hd = bus.rs1_has_dep;
        a_dep = bus.rs1_dep; a_grid = bus.get_rob_id_1;
      end else begin
        a_val = bus.rs2_val; a_hd = bus.rs2_has_dep;
        a_dep = bus.rs2_dep; a_grid = bus.get_rob_id_2;
      end
      n_tests++;
      if (a_val !== e.val || a_hd !== e.hd || a_dep !== e.dep ||
          (e.chk_grid && a_grid !== e.grid)) begin
        n_fail++;
        $display("FAIL %s: got val=%h hd=%b dep=%0d q=%0d, want val=%h hd=%b dep=%0d q=%0d",
                 e.name, a_val, a_hd, a_dep, a_grid, e.val, e.hd, e.dep, e.grid);
      end
    end
  end

  task automatic expect_rd(input int port, input string name, input logic [31:0] v,
                           input logic hd, input logic [RB-1:0] dep,
                           input bit chk_grid, input logic [RB-1:0] grid);
    exp_t e;
    e.port = port; e.name = name; e.val = v; e.hd = hd; e.dep = dep;
    e.chk_grid = chk_grid; e.grid = grid;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.rdy_in = 1'b1; bus.rob_clear = 1'b0;
    bus.set_id = '0; bus.set_val = '0; bus.set_from_rob_id = '0;
    bus.set_dep_id = '0; bus.set_dep_Q = '0;
    bus.rob_avail_1 = 1'b0; bus.rob_val_1 = '0;
    bus.rob_avail_2 = 1'b0; bus.rob_val_2 = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mark(input logic [4:0] r, input logic [RB-1:0] qv);
    idle();
    bus.set_dep_id = r; bus.set_dep_Q = qv;
    step();
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [RB-1:0] from);
    idle();
    bus.set_id = r; bus.set_val = v; bus.set_from_rob_id = from;
    step();
  endtask

  initial begin
    idle();
    bus.rs1_id = '0; bus.rs2_id = '0;

    // Reset, with a commit and mark pending that reset must override.
    rst_in = 1'b0;
    bus.set_id = 5'd5; bus.set_val = 32'h1234; bus.set_dep_id = 5'd31; bus.set_dep_Q = 4'd9;
    step(); step();
    rst_in = 1'b1;
    idle();
    bus.rs1_id = 5'd5; bus.rs2_id = 5'd31;
    expect_rd(1, "reset_rs1_x5", 32'h0, 1'b0, 4'd0, 1'b1, 4'd0);
    expect_rd(2, "reset_rs2_x31", 32'h0, 1'b0, 4'd0, 1'b1, 4'd0);
    step();

    // Mark x3 <- 7, then read pending and ROB-resolved.
    mark(5'd3, 4'd7);
    idle();
    bus.rs1_id = 5'd3;
    expect_rd(1, "x3_pending", 32'h0, 1'b1, 4'd7, 1'b1, 4'd7);
    step();
    bus.rob_avail_1 = 1'b1; bus.rob_val_1 = 32'hAB;
    expect_rd(1, "x3_rob_avail", 32'hAB, 1'b0, 4'd0, 1'b1, 4'd7);
    step();

    // Stale commit keeps the newer rename.
    mark(5'd4, 4'd2);
    mark(5'd4, 4'd5);
    commit(5'd4, 32'h11, 4'd2);
    idle();
    bus.rs1_id = 5'd4;
    expect_rd(1, "x4_stale_commit", 32'h0, 1'b1, 4'd5, 1'b1, 4'd5);
    step();
    commit(5'd4, 32'h22, 4'd5);
    idle();
    bus.rs1_id = 5'd4; bus.rs2_id = 5'd4;
    expect_rd(1, "x4_released_p1", 32'h22, 1'b0, 4'd0, 1'b1, 4'd5);
    expect_rd(2, "x4_released_p2", 32'h22, 1'b0, 4'd0, 1'b1, 4'd5);
    step();
    // Not busy: ROB answer must be ignored.
    bus.rob_avail_1 = 1'b1; bus.rob_val_1 = 32'hDEAD;
    expect_rd(1, "x4_not_busy_ignores_rob", 32'h22, 1'b0, 4'd0, 1'b1, 4'd5);
    step();

    // Same-cycle commit and mark on x6: value written, mark wins.
    mark(5'd6, 4'd1);
    idle();
    bus.set_id = 5'd6; bus.set_val = 32'h99; bus.set_from_rob_id = 4'd1;
    bus.set_dep_id = 5'd6; bus.set_dep_Q = 4'd9;
    bus.rs1_id = 5'd0; bus.rs2_id = 5'd0;
    step();
    idle();
    bus.rs1_id = 5'd6;
    expect_rd(1, "x6_mark_wins", 32'h0, 1'b1, 4'd9, 1'b1, 4'd9);
    step();
    bus.rob_clear = 1'b1;
    step();
    idle();
    bus.rs1_id = 5'd6;
    expect_rd(1, "x6_value_written", 32'h99, 1'b0, 4'd0, 1'b1, 4'd9);
    step();

    // Flush with same-cycle mark and commit.
    mark(5'd1, 4'd1);
    mark(5'd2, 4'd2);
    mark(5'd10, 4'd3);
    idle();
    bus.rob_clear = 1'b1;
    bus.set_dep_id = 5'd12; bus.set_dep_Q = 4'd4;
    bus.set_id = 5'd2; bus.set_val = 32'h5; bus.set_from_rob_id = 4'd8;
    step();
    idle();
    bus.rs1_id = 5'd1; bus.rs2_id = 5'd2;
    expect_rd(1, "clear_x1", 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    expect_rd(2, "clear_x2_val", 32'h5, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    bus.rs1_id = 5'd10; bus.rs2_id = 5'd12;
    expect_rd(1, "clear_x10", 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    expect_rd(2, "clear_x12_mark_dropped", 32'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    step();

    // x0 ignores writes and marks.
    idle();
    bus.set_id = 5'd0; bus.set_val = 32'hFFFF; bus.set_dep_id = 5'd0; bus.set_dep_Q = 4'd3;
    step();
    idle();
    bus.rs1_id = 5'd0;
    bus.rob_avail_1 = 1'b1; bus.rob_val_1 = 32'h1;
    expect_rd(1, "x0_reads_zero", 32'h0, 1'b0, 4'd0, 1'b1, 4'd0);
    step();

    // rdy_in=0 freezes state.
    idle();
    bus.rdy_in = 1'b0;
    bus.set_dep_id = 5'd8; bus.set_dep_Q = 4'd6;
    bus.set_id = 5'd8; bus.set_val = 32'h77;
    step();
    idle();
    bus.rs2_id = 5'd8;
    expect_rd(2, "x8_frozen", 32'h0, 1'b0, 4'd0, 1'b1, 4'd0);
    step();

    // Commit bypass (or ROB path without it) on x3, busy with tag 7.
    mark(5'd3, 4'd7);
    idle();
    bus.set_id = 5'd3; bus.set_val = 32'h77; bus.set_from_rob_id = 4'd7;
    bus.rs1_id = 5'd3;
`ifdef REGFILE_BYPASS_EN
    expect_rd(1, "x3_bypass", 32'h77, 1'b0, 4'd0, 1'b1, 4'd7);
`else
    expect_rd(1, "x3_no_bypass", 32'h0, 1'b1, 4'd7, 1'b1, 4'd7);
`endif
    step();
    idle();
    bus.rs1_id = 5'd3;
    expect_rd(1, "x3_committed", 32'h77, 1'b0, 4'd0, 1'b1, 4'd7);
    step();

    step();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
